if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 im_addr  output  32  fetch address, driven to the instruction memory address input.
REQ-005 im_data  input  32  instruction word returned combinationally by instruction memory for im_addr in the same cycle.
REQ-006 redirect  input  1  control-flow change request (taken branch/jump) from a later stage.
REQ-007 redirect_pc  input  32  target address, valid when redirect=1.
REQ-008 id_ready  input  1  decode stage can accept the IF/ID register contents this cycle.
REQ-009 id_valid  output  1  IF/ID register holds a valid instruction.
REQ-010 id_inst  output  32  registered instruction word.
REQ-011 id_pc  output  32  registered address of id_inst.
REQ-012 id_pc4  output  32  registered id_pc + 4.
REQ-013 fault  output  1  sticky misaligned-redirect indication.

Function
REQ-014 The block SHALL hold a 32-bit PC register and drive im_addr = PC combinationally.
REQ-015 The block SHALL implement states BOOT, RUN, FAULT.
REQ-016 BOOT: lasts exactly one cycle after reset deasserts; id_valid=0; PC unchanged; redirect ignored; next state RUN.
REQ-017 RUN, advance condition = (id_valid==0) or (id_ready==1).
REQ-018 RUN with advance and redirect=0: next cycle id_inst=im_data, id_pc=PC, id_pc4=PC+4, id_valid=1; PC<=PC+4.
REQ-019 RUN without advance and redirect=0: PC, id_valid, id_inst, id_pc, id_pc4 all SHALL hold (stall, zero data loss).
REQ-020 RUN with redirect=1 and redirect_pc[1:0]==0: PC<=redirect_pc, id_valid<=0 (flush), independent of id_ready; the first target instruction appears at id_valid one cycle later (fetch-to-decode latency 1 cycle after redirect cycle).
REQ-021 RUN with redirect=1 and redirect_pc[1:0]!=0: next state FAULT, id_valid<=0, PC held, fault<=1.
REQ-022 Redirect SHALL take priority over advance/stall when both apply in the same cycle.
REQ-023 FAULT: absorbing until reset; id_valid=0, PC held, fault=1, redirect and id_ready ignored.
REQ-024 PC arithmetic SHALL be modulo 2^32: PC=32'hFFFFFFFC advances to 32'h00000000; id_pc4 likewise wraps.
REQ-025 PC[1:0] SHALL always be 2'b00 in RUN.
REQ-026 id_inst/id_pc/id_pc4 values while id_valid=0 are don't-care for consumers but SHALL be deterministic (retain last value).

Reset
REQ-027 reset=1 at a rising edge SHALL set PC=RESET_PC, state=BOOT, id_valid=0, fault=0, id_inst=0, id_pc=0, id_pc4=0.
REQ-028 Reset SHALL override all other inputs in every state, including mid-stall, mid-redirect and FAULT.
REQ-029 While reset=1, im_addr SHALL equal RESET_PC from the first edge onward.

Verification
REQ-030 Reset release, id_ready=1, memory word n = n -> BOOT cycle id_valid=0, then id_inst=0,1,2,3 with id_pc=0,4,8,12 on consecutive cycles.
REQ-031 Hold id_ready=0 for 3 cycles with id_valid=1, id_pc=8 -> id_pc stays 8, im_addr stays 12; on id_ready=1 next id_pc=12, no instruction skipped or duplicated.
REQ-032 redirect=1, redirect_pc=0x40 while id_ready=0 and id_valid=1 -> next cycle id_valid=0, im_addr=0x40; following cycle id_valid=1, id_pc=0x40.
REQ-033 redirect=1, redirect_pc=0x42 -> fault=1, id_valid=0 thereafter; later redirect to 0x80 ignored; reset clears fault, im_addr=RESET_PC.
REQ-034 RESET_PC=32'hFFFFFFF8, id_ready=1 -> id_pc sequence FFFFFFF8, FFFFFFFC, 00000000; id_pc4 for FFFFFFFC equals 0.
REQ-035 Assert reset during a stall with id_valid=1 -> next cycle id_valid=0, PC=RESET_PC, state BOOT.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch with IF/ID register, stall, redirect/flush and sticky misaligned-target fault.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        fault
);
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, idpc_q, idpc_d, pc4_q, pc4_d;
  logic        valid_q, valid_d, fault_q, fault_d;
  assign im_addr  = pc_q;
  assign id_valid = valid_q;
  assign id_inst  = inst_q;
  assign id_pc    = idpc_q;
  assign id_pc4   = pc4_q;
  assign fault    = fault_q;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    idpc_d  = idpc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    fault_d = fault_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect) begin
          valid_d = 1'b0;
          if (redirect_pc[1:0] == 2'b00) pc_d = redirect_pc;
          else begin
            state_d = FAULT;
            fault_d = 1'b1;
          end
        end else if (!valid_q || id_ready) begin
          inst_d  = im_data;
          idpc_d  = pc_q;
          pc4_d   = pc_q + 32'd4;
          pc_d    = pc_q + 32'd4;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = FAULT;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      idpc_q  <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      idpc_q  <= idpc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end
endmodule
